// File: rtl/garage_pkg.sv
// Shared types and defaults for the two-door garage motor scheduler.
package garage_pkg;
  localparam int unsigned NUM_DOORS       = 2;
  localparam int unsigned DEF_DEAD_CYCLES = 4;
  localparam int unsigned DEF_TRAVEL_MAX  = 1000;

  typedef enum logic [1:0] {IDLE, MOVE, DEAD} state_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;
endpackage

// File: rtl/garage_rr_arbiter.sv
// Two-requester round-robin arbiter; a tie goes to the door not served last.
module garage_rr_arbiter
  import garage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DOORS-1:0] req,
  input  logic                 update,
  input  logic                 served,
  output logic [NUM_DOORS-1:0] gnt,
  output logic                 valid
);
  logic last;

  always_ff @(posedge clk) begin
    if (rst)         last <= 1'b1;
    else if (update) last <= served;
  end

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    valid = |req;
  end
endmodule

// File: rtl/garage_motor_scheduler.sv
// Shares one motor driver between two doors: edge-detected requests, round-robin
// grant, direction from limit switches, dead-time between moves and a travel watchdog.
module garage_motor_scheduler
  import garage_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int unsigned TRAVEL_MAX  = DEF_TRAVEL_MAX
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_DOORS-1:0] Activate,
  input  logic [NUM_DOORS-1:0] UP_Max,
  input  logic [NUM_DOORS-1:0] DN_Max,
  output logic [NUM_DOORS-1:0] UP_M,
  output logic [NUM_DOORS-1:0] DN_M,
  output logic                 Busy,
  output logic                 Grant,
  output logic [NUM_DOORS-1:0] Fault
);
  localparam int unsigned TW = $clog2(TRAVEL_MAX + 1);
  localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);

  state_t                 state;
  dir_t                   dir;
  logic [NUM_DOORS-1:0]   act_q, act_edge, pending, pending_n;
  logic [NUM_DOORS-1:0]   pend_set, pend_clr, fault_set;
  logic [NUM_DOORS-1:0]   arb_gnt;
  logic                   arb_valid, gidx, both_lim;
  logic                   limit_hit, timeout, stop_hit, move_exit;
  logic [TW-1:0]          travel;
  logic [DW-1:0]          dead_cnt;

  garage_rr_arbiter u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    (pending & ~Fault),
    .update (move_exit),
    .served (Grant),
    .gnt    (arb_gnt),
    .valid  (arb_valid)
  );

  assign Busy = (state != IDLE);

  // Exit priority in MOVE: limit switch, then watchdog timeout, then stop press.
  always_comb begin
    act_edge  = Activate & ~act_q;
    gidx      = arb_gnt[1];
    both_lim  = UP_Max[gidx] & DN_Max[gidx];
    limit_hit = 1'b0;
    timeout   = 1'b0;
    stop_hit  = 1'b0;
    if (state == MOVE) begin
      limit_hit = (dir == DIR_UP) ? UP_Max[Grant] : DN_Max[Grant];
      timeout   = !limit_hit && (travel == TW'(TRAVEL_MAX - 1));
      stop_hit  = !limit_hit && !timeout && act_edge[Grant];
    end
    move_exit = limit_hit | timeout | stop_hit;

    pend_set = act_edge;
    if (state == MOVE) pend_set[Grant] = 1'b0;
    pend_clr  = '0;
    fault_set = '0;
    if (state == IDLE && arb_valid) begin
      pend_clr = arb_gnt;
      if (both_lim) fault_set = arb_gnt;
    end
    if (timeout) fault_set[Grant] = 1'b1;
    pending_n = (pending | pend_set) & ~pend_clr & ~(Fault | fault_set);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      dir      <= DIR_DN;
      act_q    <= Activate;
      pending  <= '0;
      Fault    <= '0;
      UP_M     <= '0;
      DN_M     <= '0;
      Grant    <= 1'b0;
      travel   <= '0;
      dead_cnt <= '0;
    end else begin
      act_q   <= Activate;
      pending <= pending_n;
      Fault   <= Fault | fault_set;
      case (state)
        IDLE: begin
          if (arb_valid && !both_lim) begin
            state  <= MOVE;
            Grant  <= gidx;
            travel <= '0;
            if (DN_Max[gidx] && !UP_Max[gidx]) begin
              dir  <= DIR_UP;
              UP_M <= arb_gnt;
            end else begin
              dir  <= DIR_DN;
              DN_M <= arb_gnt;
            end
          end
        end
        MOVE: begin
          if (move_exit) begin
            state    <= DEAD;
            UP_M     <= '0;
            DN_M     <= '0;
            dead_cnt <= '0;
          end else begin
            travel <= travel + TW'(1);
          end
        end
        DEAD: begin
          if (dead_cnt == DW'(DEAD_CYCLES - 1)) state <= IDLE;
          else dead_cnt <= dead_cnt + DW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_garage_motor_scheduler.sv
// Directed scoreboard bench for garage_motor_scheduler with DEAD_CYCLES=4, TRAVEL_MAX=16.
module tb_garage_motor_scheduler;
  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] Activate, UP_Max, DN_Max;
  logic [1:0] UP_M, DN_M, Fault;
  logic       Busy, Grant;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string      tag;
    logic [1:0] up;
    logic [1:0] dn;
    logic       busy;
    logic       grant;
    logic [1:0] fault;
  } exp_t;
  exp_t sb[$];

  garage_motor_scheduler #(.DEAD_CYCLES(4), .TRAVEL_MAX(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Activate (Activate),
    .UP_Max   (UP_Max),
    .DN_Max   (DN_Max),
    .UP_M     (UP_M),
    .DN_M     (DN_M),
    .Busy     (Busy),
    .Grant    (Grant),
    .Fault    (Fault)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      total++;
      assert (((UP_M | DN_M) & ((UP_M | DN_M) - 2'b01)) === 2'b00 && (UP_M & DN_M) === 2'b00)
      else begin
        bad++;
        $error("FAIL invariant: observed up=%b dn=%b, expected at most one motor bit", UP_M, DN_M);
      end
    end
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] up, input logic [1:0] dn,
                            input logic busy, input logic grant, input logic [1:0] fault);
    exp_t e;
    e.tag = tag; e.up = up; e.dn = dn; e.busy = busy; e.grant = grant; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      assert ({UP_M, DN_M, Busy, Fault} === {e.up, e.dn, e.busy, e.fault})
      else begin
        bad++;
        $error("FAIL %s: observed up=%b dn=%b busy=%b fault=%b, expected up=%b dn=%b busy=%b fault=%b",
               e.tag, UP_M, DN_M, Busy, Fault, e.up, e.dn, e.busy, e.fault);
      end
      if (e.busy) begin
        total++;
        assert (Grant === e.grant)
        else begin
          bad++;
          $error("FAIL %s_grant: observed %b, expected %b", e.tag, Grant, e.grant);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; Activate = 2'b00; UP_Max = 2'b00; DN_Max = 2'b00;
    expect_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    step(2);
    check_out();
    RST = 1'b0;

    // Door 0 closed, opens upward; stopped by UP_Max after 5 cycles.
    DN_Max = 2'b01; Activate = 2'b01;
    expect_out("t1_pend", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    step(1); Activate = 2'b00;
    check_out();
    expect_out("t1_up", 2'b01, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1); check_out();
    DN_Max = 2'b00;
    expect_out("t1_move", 2'b01, 2'b00, 1'b1, 1'b0, 2'b00);
    step(4); check_out();
    UP_Max = 2'b01;
    expect_out("t1_stop", 2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1); check_out();
    expect_out("t1_dead", 2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    step(3); check_out();
    expect_out("t1_idle", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    step(1); check_out();

    // Simultaneous requests: door 0 first, door 1 after dead time.
    pulse_reset();
    UP_Max = 2'b00; DN_Max = 2'b00; Activate = 2'b11;
    step(1); Activate = 2'b00;
    expect_out("t2_d0", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00);
    step(1); check_out();
    expect_out("t2_hold", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00);
    step(2); check_out();
    DN_Max = 2'b01;
    expect_out("t2_stop", 2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
    step(1); check_out();
    DN_Max = 2'b00;
    expect_out("t2_gap", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    step(4); check_out();
    expect_out("t2_d1", 2'b00, 2'b10, 1'b1, 1'b1, 2'b00);
    step(1); check_out();
    DN_Max = 2'b10;
    expect_out("t2_d1stop", 2'b00, 2'b00, 1'b1, 1'b1, 2'b00);
    step(1); check_out();
    expect_out("t2_end", 2'b00, 2'b00, 1'b0, 1'b1, 2'b00);
    step(6); check_out();

    // Door 1 moving up, second press stops it without reversal or a new request.
    pulse_reset();
    UP_Max = 2'b00; DN_Max = 2'b10; Activate = 2'b10;
    step(1); Activate = 2'b00;
    expect_out("t3_up", 2'b10, 2'b00, 1'b1, 1'b1, 2'b00);
    step(1); check_out();
    step(2);
    Activate = 2'b10;
    expect_out("t3_stop", 2'b00, 2'b00, 1'b1, 1'b1, 2'b00);
    step(1); check_out();
    Activate = 2'b00;
    expect_out("t3_idle", 2'b00, 2'b00, 1'b0, 1'b1, 2'b00);
    step(4); check_out();
    expect_out("t3_nopend", 2'b00, 2'b00, 1'b0, 1'b1, 2'b00);
    step(2); check_out();

    // Watchdog: door 0 never reaches a limit.
    pulse_reset();
    UP_Max = 2'b00; DN_Max = 2'b00; Activate = 2'b01;
    step(1); Activate = 2'b00;
    expect_out("t4_dn", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00);
    step(1); check_out();
    expect_out("t4_pre", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00);
    step(15); check_out();
    expect_out("t4_fault", 2'b00, 2'b00, 1'b1, 1'b0, 2'b01);
    step(1); check_out();
    expect_out("t4_idle", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01);
    step(4); check_out();
    Activate = 2'b01;
    step(1); Activate = 2'b00;
    expect_out("t4_ignored", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01);
    step(3); check_out();

    // Both limits on door 1: mis-wired, fault without motion.
    pulse_reset();
    UP_Max = 2'b10; DN_Max = 2'b10; Activate = 2'b10;
    step(1); Activate = 2'b00;
    expect_out("t5_fault", 2'b00, 2'b00, 1'b0, 1'b0, 2'b10);
    step(1); check_out();
    expect_out("t5_stay", 2'b00, 2'b00, 1'b0, 1'b0, 2'b10);
    step(2); check_out();

    // Reset mid-move with the button held: no restart without a fresh edge.
    pulse_reset();
    UP_Max = 2'b00; DN_Max = 2'b00; Activate = 2'b01;
    step(1);
    expect_out("t6_move", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00);
    step(1); check_out();
    step(2);
    RST = 1'b1;
    expect_out("t6_rst", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    step(1); check_out();
    step(1); RST = 1'b0;
    expect_out("t6_norestart", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    step(3); check_out();
    Activate = 2'b00;
    step(1); Activate = 2'b01;
    expect_out("t6_fresh", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00);
    step(2); check_out();
    Activate = 2'b00;

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
